qbus_master: RTL

QBUS_MASTER -- requirements
Module: qbus_master

---
 rtl/qbus_pkg.sv | 18 +
 rtl/qbus_master_if.sv | 39 +++
 rtl/qbus_sync.sv | 26 ++
 rtl/qbus_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared QBUS master definitions: FSM state encoding and default timing constants.
package qbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        SYNC,
        DATA,
        WAIT,
        TERM,
        REL
    } qbus_state_e;

    localparam int unsigned ADDR_SETUP_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 64;

endpackage

// File: rtl/qbus_master_if.sv
// Command-side handshake plus QBUS pins of the master, with master/slave views.
interface qbus_master_if;

    logic        cmd_req;
    logic        cmd_we;
    logic        cmd_byte;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        busy;
    logic        cmd_ack;
    logic        cmd_err;
    logic [15:0] cmd_rdata;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    logic [15:0] ad_in_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        rply_n;
    logic        dmr_n;
    logic        dmgi_n;
    logic        sack_n;

    modport master (
        input  cmd_req, cmd_we, cmd_byte, cmd_addr, cmd_wdata,
        input  ad_in_n, rply_n, dmgi_n,
        output busy, cmd_ack, cmd_err, cmd_rdata,
        output ad_out_n, ad_oe, sync_n, din_n, dout_n, wtbt_n, dmr_n, sack_n
    );

    modport slave (
        output cmd_req, cmd_we, cmd_byte, cmd_addr, cmd_wdata,
        output ad_in_n, rply_n, dmgi_n,
        input  busy, cmd_ack, cmd_err, cmd_rdata,
        input  ad_out_n, ad_oe, sync_n, din_n, dout_n, wtbt_n, dmr_n, sack_n
    );

endinterface

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for one asynchronous bus line; resets to RESET_VAL.
module qbus_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/qbus_master.sv
// QBUS single-transfer master (DATI/DATO/DATOB) with reply timeout.
// Define QBUS_MASTER_DMA_EN to build the DMR/DMGI/SACK bus-request phase.
module qbus_master
    import qbus_pkg::*;
#(
    parameter int unsigned ADDR_SETUP = ADDR_SETUP_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    qbus_master_if.master bus
);

    localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    qbus_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        err_q, err_d;
    logic        sack_q, sack_d;
    logic        rply_s;

    qbus_sync #(.RESET_VAL(1'b1)) u_rply_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rply_n),
        .q_o (rply_s)
    );

`ifdef QBUS_MASTER_DMA_EN
    logic dmgi_s;

    qbus_sync #(.RESET_VAL(1'b1)) u_dmgi_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.dmgi_n),
        .q_o (dmgi_s)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            sack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            sack_q  <= sack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        err_d   = err_q;
        sack_d  = sack_q;

        bus.busy      = (state_q != IDLE);
        bus.cmd_ack   = 1'b0;
        bus.cmd_err   = err_q;
        bus.cmd_rdata = rdata_q;
        bus.ad_out_n  = '1;
        bus.ad_oe     = 1'b0;
        bus.sync_n    = 1'b1;
        bus.din_n     = 1'b1;
        bus.dout_n    = 1'b1;
        bus.wtbt_n    = 1'b1;
        bus.dmr_n     = 1'b1;
        bus.sack_n    = ~sack_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_req) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    we_d    = bus.cmd_we;
                    byte_d  = bus.cmd_byte;
                    err_d   = 1'b0;
                    cnt_d   = '0;
`ifdef QBUS_MASTER_DMA_EN
                    state_d = REQ;
`else
                    state_d = ADDR;
`endif
                end
            end
`ifdef QBUS_MASTER_DMA_EN
            REQ: begin
                bus.dmr_n = 1'b0;
                if (!dmgi_s) begin
                    sack_d  = 1'b1;
                    state_d = ADDR;
                end
            end
`endif
            ADDR: begin
                bus.ad_oe    = 1'b1;
                bus.ad_out_n = ~addr_q;
                bus.wtbt_n   = ~we_q;
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = SYNC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SYNC: begin
                bus.ad_oe    = 1'b1;
                bus.ad_out_n = ~addr_q;
                bus.wtbt_n   = ~we_q;
                bus.sync_n   = 1'b0;
                state_d      = DATA;
            end
            DATA: begin
                bus.sync_n   = 1'b0;
                bus.ad_oe    = we_q;
                bus.ad_out_n = we_q ? ~wdata_q : '1;
                bus.wtbt_n   = we_q ? ~byte_q : 1'b1;
                cnt_d        = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                bus.sync_n   = 1'b0;
                bus.ad_oe    = we_q;
                bus.ad_out_n = we_q ? ~wdata_q : '1;
                bus.wtbt_n   = we_q ? ~byte_q : 1'b1;
                bus.din_n    = we_q;
                bus.dout_n   = ~we_q;
                if (!rply_s) begin
                    if (!we_q) begin
                        rdata_d = ~bus.ad_in_n;
                    end
                    cnt_d   = '0;
                    state_d = TERM;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TERM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TERM: begin
                // SYNC stays asserted until the slave drops RPLY (or we give up).
                bus.sync_n = 1'b0;
                bus.wtbt_n = we_q ? ~byte_q : 1'b1;
                if (err_q || rply_s) begin
                    sack_d  = 1'b0;
                    state_d = REL;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    sack_d  = 1'b0;
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REL: begin
                bus.cmd_ack = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
